// File: rtl/cameralink_pkg.sv
// cameralink_pkg: shared definitions for the CameraLink-over-SIMBUS transmitter
// and the receiver wrapper.
//   - cl_state_t : transmitter frame/line state machine encoding
//   - CL_*       : bit positions inside the packed 27-bit p2p word
//   - cl_cnt_w   : counter width helper (never returns less than 1)
package cameralink_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VPRE,
    S_LINE,
    S_HBLANK,
    S_VBLANK
  } cl_state_t;

  localparam int unsigned CL_WORD_W    = 27;
  localparam int unsigned CL_FVV_BIT   = 26;
  localparam int unsigned CL_LVV_BIT   = 25;
  localparam int unsigned CL_VCE_BIT   = 24;
  localparam int unsigned CL_BLUE_LSB  = 16;
  localparam int unsigned CL_GREEN_LSB = 8;
  localparam int unsigned CL_RED_LSB   = 0;
  localparam int unsigned CL_CHAN_W    = 8;

  // Bits needed to count 0..n-1.
  function automatic int unsigned cl_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cameralink_blank_timer.sv
// cameralink_blank_timer: loadable down-counter used for the VPRE, HBLANK and
// VBLANK intervals. Loading N-1 on entry to a state makes done_c rise on the
// N-th cycle spent in that state.
//   clock, reset : bus clock, asynchronous active-high reset
//   load         : load load_val on the next edge
//   load_val     : interval length minus one
//   done_c       : combinational, counter has reached zero
module cameralink_blank_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/cameralink_send.sv
// cameralink_send: camera-side CameraLink model on the SIMBUS point-to-point bus.
// Generates FVV/LVV/VCE timing with a test-pattern payload (red = x, green = y,
// blue = completed frame count), gated by cam_enable and cam_request.
//   clock, reset        : bus clock, asynchronous active-high reset
//   cam_enable          : grabber permits output; low aborts a running frame
//   cam_request         : frame trigger, level-sampled in IDLE
//   FVV, LVV, VCE       : frame / line / pixel valid
//   red, green, blue    : pixel payload, zero whenever VCE is low
//   data_o              : packed {FVV, LVV, VCE, blue, green, red}
//   busy                : not IDLE
//   frame_done          : pulse in the first VBLANK cycle of a completed frame
//   frame_aborted       : pulse in the first VBLANK cycle of an aborted frame
//   frame_count         : completed frames, wraps at 16 bits
module cameralink_send
  import cameralink_pkg::*;
#(
  parameter int unsigned WIDTH   = 640,
  parameter int unsigned HEIGHT  = 480,
  parameter int unsigned VPRE    = 4,
  parameter int unsigned HBLANK  = 16,
  parameter int unsigned VBLANK  = 32,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cam_enable,
  input  logic                 cam_request,
  output logic                 FVV,
  output logic                 LVV,
  output logic                 VCE,
  output logic [CL_CHAN_W-1:0] red,
  output logic [CL_CHAN_W-1:0] green,
  output logic [CL_CHAN_W-1:0] blue,
  output logic [CL_WORD_W-1:0] data_o,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_aborted,
  output logic [15:0]          frame_count
);

  localparam int unsigned XW   = cl_cnt_w(WIDTH);
  localparam int unsigned YW   = cl_cnt_w(HEIGHT);
  localparam int unsigned DW   = cl_cnt_w(CLK_DIV);
  localparam int unsigned TMAX = (VPRE > HBLANK) ? ((VPRE > VBLANK) ? VPRE : VBLANK)
                                                 : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int unsigned TW   = cl_cnt_w(TMAX);

  cl_state_t state, state_n;

  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [DW-1:0] div, div_n;
  logic [15:0]   fcount_n;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_done_c;

  logic                 fvv_n, lvv_n, vce_n, busy_n, done_n, aborted_n;
  logic [CL_CHAN_W-1:0] red_n, green_n, blue_n;

  cameralink_blank_timer #(
    .W (TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done_c   (timer_done_c)
  );

  // Next-state, counter and next-output logic. Outputs are derived from the
  // next state so the registered outputs line up with the state they describe.
  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    div_n      = div;
    fcount_n   = frame_count;
    timer_load = 1'b0;
    timer_val  = '0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;

    // Losing the enable mid-frame takes priority over any normal transition.
    if ((state inside {S_VPRE, S_LINE, S_HBLANK}) && !cam_enable) begin
      state_n    = S_VBLANK;
      timer_load = 1'b1;
      timer_val  = TW'(VBLANK - 1);
      aborted_n  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cam_enable && cam_request) begin
            state_n    = S_VPRE;
            timer_load = 1'b1;
            timer_val  = TW'(VPRE - 1);
          end
        end
        S_VPRE: begin
          if (timer_done_c) begin
            state_n = S_LINE;
            x_n     = '0;
            y_n     = '0;
            div_n   = '0;
          end
        end
        S_LINE: begin
          if (div == DW'(CLK_DIV - 1)) begin
            div_n = '0;
            if (x == XW'(WIDTH - 1)) begin
              if (y == YW'(HEIGHT - 1)) begin
                state_n    = S_VBLANK;
                timer_load = 1'b1;
                timer_val  = TW'(VBLANK - 1);
                done_n     = 1'b1;
                fcount_n   = frame_count + 16'd1;
              end else begin
                state_n    = S_HBLANK;
                timer_load = 1'b1;
                timer_val  = TW'(HBLANK - 1);
              end
            end else begin
              x_n = x + XW'(1);
            end
          end else begin
            div_n = div + DW'(1);
          end
        end
        S_HBLANK: begin
          if (timer_done_c) begin
            state_n = S_LINE;
            x_n     = '0;
            y_n     = y + YW'(1);
            div_n   = '0;
          end
        end
        S_VBLANK: begin
          if (timer_done_c) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end

    fvv_n   = (state_n inside {S_VPRE, S_LINE, S_HBLANK});
    lvv_n   = (state_n == S_LINE);
    vce_n   = lvv_n && (div_n == '0);
    busy_n  = (state_n != S_IDLE);
    red_n   = vce_n ? CL_CHAN_W'(x_n) : '0;
    green_n = vce_n ? CL_CHAN_W'(y_n) : '0;
    blue_n  = vce_n ? fcount_n[CL_CHAN_W-1:0] : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      div           <= '0;
      frame_count   <= '0;
      FVV           <= 1'b0;
      LVV           <= 1'b0;
      VCE           <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      div           <= div_n;
      frame_count   <= fcount_n;
      FVV           <= fvv_n;
      LVV           <= lvv_n;
      VCE           <= vce_n;
      red           <= red_n;
      green         <= green_n;
      blue          <= blue_n;
      busy          <= busy_n;
      frame_done    <= done_n;
      frame_aborted <= aborted_n;
    end
  end

  // Packed bus word, pure wiring of the output registers.
  always_comb begin
    data_o                                = '0;
    data_o[CL_FVV_BIT]                    = FVV;
    data_o[CL_LVV_BIT]                    = LVV;
    data_o[CL_VCE_BIT]                    = VCE;
    data_o[CL_BLUE_LSB  +: CL_CHAN_W]     = blue;
    data_o[CL_GREEN_LSB +: CL_CHAN_W]     = green;
    data_o[CL_RED_LSB   +: CL_CHAN_W]     = red;
  end

endmodule

// File: tb/tb_cameralink_send.sv
// tb_cameralink_send: directed self-checking bench for cameralink_send.
// Three instances cover the basic 4x2 frame, CLK_DIV=2 and 8-bit x wrap.
// Cycle c is the interval after rising edge c; inputs change 1 time unit after
// an edge, outputs are sampled on the falling edge.
module tb_cameralink_send;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // basic instance: WIDTH=4 HEIGHT=2 VPRE=2 HBLANK=3 VBLANK=5 CLK_DIV=1
  logic b_en = 1'b0, b_req = 1'b0;
  logic b_fvv, b_lvv, b_vce, b_busy, b_done, b_abt;
  logic [7:0] b_red, b_green, b_blue;
  logic [26:0] b_data;
  logic [15:0] b_cnt;

  // divider instance: WIDTH=3 HEIGHT=1 VPRE=2 HBLANK=3 VBLANK=5 CLK_DIV=2
  logic d_en = 1'b0, d_req = 1'b0;
  logic d_fvv, d_lvv, d_vce, d_busy, d_done, d_abt;
  logic [7:0] d_red, d_green, d_blue;
  logic [26:0] d_data;
  logic [15:0] d_cnt;

  // wrap instance: WIDTH=300 HEIGHT=1 VPRE=1 HBLANK=1 VBLANK=2 CLK_DIV=1
  logic w_en = 1'b0, w_req = 1'b0;
  logic w_fvv, w_lvv, w_vce, w_busy, w_done, w_abt;
  logic [7:0] w_red, w_green, w_blue;
  logic [26:0] w_data;
  logic [15:0] w_cnt;

  cameralink_send #(
    .WIDTH(4), .HEIGHT(2), .VPRE(2), .HBLANK(3), .VBLANK(5), .CLK_DIV(1)
  ) u_basic (
    .clock(clock), .reset(reset), .cam_enable(b_en), .cam_request(b_req),
    .FVV(b_fvv), .LVV(b_lvv), .VCE(b_vce), .red(b_red), .green(b_green), .blue(b_blue),
    .data_o(b_data), .busy(b_busy), .frame_done(b_done), .frame_aborted(b_abt),
    .frame_count(b_cnt)
  );

  cameralink_send #(
    .WIDTH(3), .HEIGHT(1), .VPRE(2), .HBLANK(3), .VBLANK(5), .CLK_DIV(2)
  ) u_div (
    .clock(clock), .reset(reset), .cam_enable(d_en), .cam_request(d_req),
    .FVV(d_fvv), .LVV(d_lvv), .VCE(d_vce), .red(d_red), .green(d_green), .blue(d_blue),
    .data_o(d_data), .busy(d_busy), .frame_done(d_done), .frame_aborted(d_abt),
    .frame_count(d_cnt)
  );

  cameralink_send #(
    .WIDTH(300), .HEIGHT(1), .VPRE(1), .HBLANK(1), .VBLANK(2), .CLK_DIV(1)
  ) u_wrap (
    .clock(clock), .reset(reset), .cam_enable(w_en), .cam_request(w_req),
    .FVV(w_fvv), .LVV(w_lvv), .VCE(w_vce), .red(w_red), .green(w_green), .blue(w_blue),
    .data_o(w_data), .busy(w_busy), .frame_done(w_done), .frame_aborted(w_abt),
    .frame_count(w_cnt)
  );

  // Expected {FVV,LVV,VCE,blue,green,red} of the basic 4x2 frame, o cycles
  // after FVV rises: VPRE o=0..1, line0 o=2..5, HBLANK o=6..8, line1 o=9..12.
  function automatic logic [26:0] exp_basic_word(input int o, input logic [7:0] blu);
    logic fv, lv;
    logic [7:0] r, g, bl;
    fv = (o >= 0) && (o <= 12);
    lv = ((o >= 2) && (o <= 5)) || ((o >= 9) && (o <= 12));
    r  = 8'd0;
    g  = 8'd0;
    bl = 8'd0;
    if (lv) begin
      r  = (o <= 5) ? 8'(o - 2) : 8'(o - 9);
      g  = (o >= 9) ? 8'd1 : 8'd0;
      bl = blu;
    end
    return {fv, lv, lv, bl, g, r};
  endfunction

  task automatic apply_reset();
    b_en = 1'b0; b_req = 1'b0;
    d_en = 1'b0; d_req = 1'b0;
    w_en = 1'b0; w_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    b_en = 1'b1; b_req = 1'b1;
    d_en = 1'b1; d_req = 1'b1;
    w_en = 1'b1; w_req = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({b_fvv, b_lvv, b_vce, b_red, b_green, b_blue, b_data, b_busy, b_done, b_abt, b_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_basic got=%h required=0",
               {b_fvv, b_lvv, b_vce, b_red, b_green, b_blue, b_data, b_busy, b_done, b_abt, b_cnt});
    end
    checks++;
    if ({d_fvv, d_lvv, d_vce, d_red, d_green, d_blue, d_data, d_busy, d_done, d_abt, d_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_div got=%h required=0",
               {d_fvv, d_lvv, d_vce, d_red, d_green, d_blue, d_data, d_busy, d_done, d_abt, d_cnt});
    end
    checks++;
    if ({w_fvv, w_lvv, w_vce, w_red, w_green, w_blue, w_data, w_busy, w_done, w_abt, w_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_wrap got=%h required=0",
               {w_fvv, w_lvv, w_vce, w_red, w_green, w_blue, w_data, w_busy, w_done, w_abt, w_cnt});
    end
  endtask

  task automatic test_basic_frame();
    logic [26:0] ew;
    logic [2:0]  ef;
    logic [15:0] ec;
    int o;
    apply_reset();
    b_en = 1'b1; b_req = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clock);
      o  = c - 1;
      ew = exp_basic_word(o, 8'd0);
      ef = {(o >= 0) && (o <= 17), o == 13, 1'b0};
      ec = (o >= 13) ? 16'd1 : 16'd0;
      checks++;
      if ({b_fvv, b_lvv, b_vce, b_blue, b_green, b_red} !== ew) begin
        failures++;
        $display("FAIL basic_pins c=%0d got=%h required=%h", c, {b_fvv, b_lvv, b_vce, b_blue, b_green, b_red}, ew);
      end
      checks++;
      if (b_data !== ew) begin
        failures++;
        $display("FAIL basic_data_o c=%0d got=%h required=%h", c, b_data, ew);
      end
      checks++;
      if ({b_busy, b_done, b_abt} !== ef) begin
        failures++;
        $display("FAIL basic_flags c=%0d got=%b required=%b", c, {b_busy, b_done, b_abt}, ef);
      end
      checks++;
      if (b_cnt !== ec) begin
        failures++;
        $display("FAIL basic_count c=%0d got=%0d required=%0d", c, b_cnt, ec);
      end
      @(posedge clock);
      #1;
      b_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] ew;
    logic [2:0]  ef;
    logic [15:0] ec;
    int o;
    apply_reset();
    b_en = 1'b1; b_req = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      @(negedge clock);
      if (c < 20) begin
        o  = c - 1;
        ew = exp_basic_word(o, 8'd0);
        ec = (o >= 13) ? 16'd1 : 16'd0;
      end else begin
        o  = c - 20;
        ew = exp_basic_word(o, 8'd1);
        ec = (o >= 13) ? 16'd2 : 16'd1;
      end
      ef = {(o >= 0) && (o <= 17), o == 13, 1'b0};
      checks++;
      if (b_data !== ew) begin
        failures++;
        $display("FAIL b2b_data_o c=%0d got=%h required=%h", c, b_data, ew);
      end
      checks++;
      if ({b_busy, b_done, b_abt} !== ef) begin
        failures++;
        $display("FAIL b2b_flags c=%0d got=%b required=%b", c, {b_busy, b_done, b_abt}, ef);
      end
      checks++;
      if (b_cnt !== ec) begin
        failures++;
        $display("FAIL b2b_count c=%0d got=%0d required=%0d", c, b_cnt, ec);
      end
      @(posedge clock);
      #1;
      if (c == 30) b_req = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [26:0] ew;
    logic [2:0]  ef;
    apply_reset();
    b_en = 1'b1; b_req = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clock);
      if (c <= 8) begin
        ew = exp_basic_word(c - 1, 8'd0);
        ef = {c >= 1, 1'b0, 1'b0};
      end else begin
        ew = '0;
        ef = {c <= 13, 1'b0, c == 9};
      end
      checks++;
      if (b_data !== ew) begin
        failures++;
        $display("FAIL abort_data_o c=%0d got=%h required=%h", c, b_data, ew);
      end
      checks++;
      if ({b_busy, b_done, b_abt} !== ef) begin
        failures++;
        $display("FAIL abort_flags c=%0d got=%b required=%b", c, {b_busy, b_done, b_abt}, ef);
      end
      checks++;
      if (b_cnt !== 16'd0) begin
        failures++;
        $display("FAIL abort_count c=%0d got=%0d required=0", c, b_cnt);
      end
      @(posedge clock);
      #1;
      b_req = (c >= 12);   // request held from cycle 13 while disabled: must not start
      if (c == 7) b_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_line();
    logic [26:0] ew;
    apply_reset();
    b_en = 1'b1; b_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      ew = exp_basic_word(c - 1, 8'd0);
      checks++;
      if (b_data !== ew) begin
        failures++;
        $display("FAIL midreset_pre c=%0d got=%h required=%h", c, b_data, ew);
      end
      if (c < 5) begin
        @(posedge clock);
        #1;
        b_req = 1'b0;
      end
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({b_fvv, b_lvv, b_vce, b_red, b_green, b_blue, b_data, b_busy, b_done, b_abt, b_cnt} !== '0) begin
      failures++;
      $display("FAIL midreset_async got=%h required=0",
               {b_fvv, b_lvv, b_vce, b_red, b_green, b_blue, b_data, b_busy, b_done, b_abt, b_cnt});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    b_req = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      ew = exp_basic_word(c - 1, 8'd0);
      checks++;
      if (b_data !== ew) begin
        failures++;
        $display("FAIL midreset_restart c=%0d got=%h required=%h", c, b_data, ew);
      end
      @(posedge clock);
      #1;
      b_req = 1'b0;
    end
  endtask

  task automatic test_clk_div();
    logic [26:0] ew;
    logic [2:0]  ef;
    logic [15:0] ec;
    logic fv, lv, vc;
    logic [7:0] r;
    apply_reset();
    d_en = 1'b1; d_req = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clock);
      fv = (c >= 1) && (c <= 8);
      lv = (c >= 3) && (c <= 8);
      vc = lv && (((c - 3) % 2) == 0);
      r  = vc ? 8'((c - 3) / 2) : 8'd0;
      ew = {fv, lv, vc, 8'd0, 8'd0, r};
      ef = {(c >= 1) && (c <= 13), c == 9, 1'b0};
      ec = (c >= 9) ? 16'd1 : 16'd0;
      checks++;
      if ({d_fvv, d_lvv, d_vce, d_blue, d_green, d_red} !== ew) begin
        failures++;
        $display("FAIL div_pins c=%0d got=%h required=%h", c, {d_fvv, d_lvv, d_vce, d_blue, d_green, d_red}, ew);
      end
      checks++;
      if (d_data !== ew) begin
        failures++;
        $display("FAIL div_data_o c=%0d got=%h required=%h", c, d_data, ew);
      end
      checks++;
      if ({d_busy, d_done, d_abt} !== ef) begin
        failures++;
        $display("FAIL div_flags c=%0d got=%b required=%b", c, {d_busy, d_done, d_abt}, ef);
      end
      checks++;
      if (d_cnt !== ec) begin
        failures++;
        $display("FAIL div_count c=%0d got=%0d required=%0d", c, d_cnt, ec);
      end
      @(posedge clock);
      #1;
      d_req = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [26:0] ew;
    logic [2:0]  ef;
    logic [15:0] ec;
    logic fv, lv;
    logic [7:0] r;
    apply_reset();
    w_en = 1'b1; w_req = 1'b1;
    for (int c = 0; c <= 305; c++) begin
      @(negedge clock);
      fv = (c >= 1) && (c <= 301);
      lv = (c >= 2) && (c <= 301);
      r  = lv ? 8'(c - 2) : 8'd0;
      ew = {fv, lv, lv, 8'd0, 8'd0, r};
      ef = {(c >= 1) && (c <= 303), c == 302, 1'b0};
      ec = (c >= 302) ? 16'd1 : 16'd0;
      checks++;
      if ({w_fvv, w_lvv, w_vce, w_blue, w_green, w_red} !== ew) begin
        failures++;
        $display("FAIL wrap_pins c=%0d got=%h required=%h", c, {w_fvv, w_lvv, w_vce, w_blue, w_green, w_red}, ew);
      end
      checks++;
      if (w_data !== ew) begin
        failures++;
        $display("FAIL wrap_data_o c=%0d got=%h required=%h", c, w_data, ew);
      end
      checks++;
      if ({w_busy, w_done, w_abt} !== ef) begin
        failures++;
        $display("FAIL wrap_flags c=%0d got=%b required=%b", c, {w_busy, w_done, w_abt}, ef);
      end
      checks++;
      if (w_cnt !== ec) begin
        failures++;
        $display("FAIL wrap_count c=%0d got=%0d required=%0d", c, w_cnt, ec);
      end
      @(posedge clock);
      #1;
      w_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_abort();
    test_reset_mid_line();
    test_clk_div();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cameralink_send.md
Name: cameralink_send

Overview:
- Camera-side (transmitter) model for CameraLink carried over the SIMBUS point-to-point bus.
- Generates frame, line and pixel timing (FVV/LVV/VCE) with a deterministic test-pattern RGB payload.
- Generation is gated by the frame grabber's cam_enable and cam_request.
- Outputs are also presented as the packed 27-bit p2p word that a point-master wrapper places on the bus.

Parameters:
- WIDTH, 640: pixels per line (>=1).
- HEIGHT, 480: lines per frame (>=1).
- VPRE, 4: cycles FVV is high before the first line (>=1).
- HBLANK, 16: cycles between lines with FVV=1, LVV=0 (>=1); not applied after the last line.
- VBLANK, 32: cycles with FVV=0 after a frame ends or is aborted, before a new frame may start (>=1).
- CLK_DIV, 1: VCE asserts once every CLK_DIV cycles within a line (>=1).

Ports:
- clock  in  1  single bus clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cam_enable  in  1  grabber permits camera output; low aborts a frame in progress.
- cam_request  in  1  frame trigger, level-sampled in IDLE.
- FVV  out  1  frame valid.
- LVV  out  1  line valid.
- VCE  out  1  pixel (data) valid.
- red  out  8  pixel x index [7:0].
- green  out  8  line y index [7:0].
- blue  out  8  frame_count [7:0].
- data_o  out  27  packed word {FVV, LVV, VCE, blue, green, red}: bit 26 = FVV, 25 = LVV, 24 = VCE, [23:16] = blue, [15:8] = green, [7:0] = red.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when a complete frame ends.
- frame_aborted  out  1  one-cycle pulse when cam_enable aborts a frame.
- frame_count  out  16  count of completed frames.

Behaviour:
- Reset: all outputs are registered and reset to 0. State = IDLE; x, y, divider and blanking counters = 0.
- States and transitions:
  - IDLE: if cam_enable && cam_request at an edge, go to VPRE; FVV=1 from the next cycle (1-cycle latency).
  - VPRE: FVV=1 for VPRE cycles, then LINE with y=0.
  - LINE: FVV=1, LVV=1 for WIDTH*CLK_DIV cycles.
    - VCE=1 on the first cycle of each CLK_DIV group; x increments after each VCE.
    - red/green/blue are valid only when VCE=1 and forced to 0 whenever VCE=0.
    - At line end: if y==HEIGHT-1, go to VBLANK; otherwise go to HBLANK.
  - HBLANK: FVV=1, LVV=0, VCE=0 for HBLANK cycles; then y increments, x=0, back to LINE.
  - VBLANK: FVV=LVV=VCE=0 for VBLANK cycles, then IDLE.
    - cam_request is ignored during VBLANK.
    - A request still high on the first IDLE cycle starts the next frame, so a held request gives back-to-back frames separated by VBLANK+1 idle-to-FVV cycles.
- Frame completion: on entry to VBLANK from LINE, frame_done pulses in the first VBLANK cycle and frame_count increments in the same cycle. frame_count wraps 0xFFFF->0.
- Abort: cam_enable sampled low in VPRE, LINE or HBLANK goes to VBLANK next cycle.
  - FVV, LVV and VCE drop in that cycle; frame_aborted pulses.
  - frame_count is unchanged and frame_done does not pulse.
  - cam_enable low in IDLE or VBLANK has no effect beyond blocking a start.
- Width rules: x and y counters are sized to $clog2 of their maximum. The 8-bit outputs are the low bits, so values wrap modulo 256.
- Invariants: LVV implies FVV; VCE implies LVV.
- Reset mid-frame: outputs drop asynchronously to 0 and the block resumes in IDLE.

Decomposition:
- Shared package cameralink_pkg holds:
  - the state enum (IDLE, VPRE, LINE, HBLANK, VBLANK);
  - packed-word bit positions CL_FVV_BIT=26, CL_LVV_BIT=25, CL_VCE_BIT=24, CL_BLUE_LSB=16, CL_GREEN_LSB=8, CL_RED_LSB=0, CL_WORD_W=27.
- The receiver wrapper imports the same constants.
- One sub-module, cameralink_blank_timer: loadable down-counter with a done flag, shared by VPRE, HBLANK and VBLANK.

Test Plan:
- Basic frame (WIDTH=4, HEIGHT=2, VPRE=2, HBLANK=3, VBLANK=5, CLK_DIV=1), enable=1, request pulsed 1 cycle at edge 0:
  - FVV high cycles 1-13; LVV/VCE high cycles 3-6 and 10-13;
  - red=0,1,2,3 per line; green=0 then 1; blue=0;
  - frame_done at cycle 14, frame_count=1; busy low from cycle 19.
- Held request, same parameters: second frame FVV rises at cycle 20 with blue=1; frame_count=2 after it.
- CLK_DIV=2, WIDTH=3: LVV high 6 cycles per line; VCE on alternate cycles with red=0,1,2; data zeroed on non-VCE cycles.
- Abort: enable dropped at edge of cycle 8 (HBLANK) in the basic case:
  - FVV=LVV=0 at cycle 9; frame_aborted pulse at 9;
  - no frame_done; frame_count unchanged; IDLE after 5 VBLANK cycles.
- Reset asserted mid-LINE: all outputs 0 immediately and asynchronously; after release, request starts a fresh frame with red=0, green=0.
- Wrap: WIDTH=300: red sequence ...254,255,0,1...; data_o[7:0]==red and data_o[26:24]=={FVV,LVV,VCE} every cycle.
